// File: rtl/shift_cmd_queue.sv
`default_nettype none
// ============================================================================
// Module      : shift_cmd_queue
// Description : Buffered issue stage ahead of a 4-bit barrel shifter.
//               Shift commands (data, amount) enter a circular FIFO over a
//               valid/ready handshake. The head command drives the shifter,
//               and the shifter result is captured with loss/zero flags into
//               a registered valid/ready output slot. Sustains one shift per
//               clock.
// Ports       : clk, rst          - clock, asynchronous active-high reset
//               in_valid/in_ready - command handshake, in_a data, in_b amount
//               sh_a/sh_b         - head command to shifter (0 when empty)
//               sh_result         - combinational shifter result
//               out_valid/ready   - result handshake, out_result registered
//               out_lost/out_zero - 1-bit shifted out / result is zero
//               count             - FIFO occupancy 0..DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module shift_cmd_queue #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [3:0]               in_a,
   input  logic [3:0]               in_b,
   output logic [3:0]               sh_a,
   output logic [3:0]               sh_b,
   input  logic [3:0]               sh_result,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [3:0]               out_result,
   output logic                     out_lost,
   output logic                     out_zero,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

   // Each entry packs {data, amount}
   logic [7:0]        mem_q [DEPTH];
   logic [7:0]        mem_d [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              out_valid_q, out_valid_d;
   logic [3:0]        out_result_q, out_result_d;
   logic              out_lost_q, out_lost_d;
   logic              out_zero_q, out_zero_d;

   logic              fifo_empty;
   logic              fifo_full;
   logic              do_push;
   logic              do_load;
   logic [7:0]        head;
   logic [3:0]        rsh_amt;
   logic              lost_calc;

   // Head and ready depend on registered state only
   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == FULL_COUNT);
   assign head       = mem_q[rd_ptr_q];
   assign sh_a       = fifo_empty ? 4'h0 : head[7:4];
   assign sh_b       = fifo_empty ? 4'h0 : head[3:0];
   assign in_ready   = !fifo_full;

   // A push is refused when full even if a pop happens in the same cycle
   assign do_push = in_valid && !fifo_full;
   assign do_load = !fifo_empty && (!out_valid_q || out_ready);

   // A set bit is lost if it lands at position 4 or above after the shift:
   // either the amount clears the whole nibble, or some of the top sh_b bits
   // of the data are set. rsh_amt is only meaningful for sh_b in 1..3.
   assign rsh_amt   = 4'd4 - sh_b;
   assign lost_calc = (sh_a != 4'h0) && (sh_b != 4'h0) &&
                      ((sh_b >= 4'd4) || ((sh_a >> rsh_amt) != 4'h0));

   always_comb begin
      mem_d        = mem_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      out_valid_d  = out_valid_q;
      out_result_d = out_result_q;
      out_lost_d   = out_lost_q;
      out_zero_d   = out_zero_q;

      if (do_push) begin
         mem_d[wr_ptr_q] = {in_a, in_b};
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end

      if (do_load) begin
         rd_ptr_d     = rd_ptr_q + PTR_W'(1);
         out_valid_d  = 1'b1;
         out_result_d = sh_result;
         out_zero_d   = (sh_result == 4'h0);
         out_lost_d   = lost_calc;
      end else if (out_valid_q && out_ready) begin
         // Slot drained with nothing to refill it; data/flags keep last value
         out_valid_d = 1'b0;
      end

      case ({do_push, do_load})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= 8'h00;
         end
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         out_valid_q  <= 1'b0;
         out_result_q <= 4'h0;
         out_lost_q   <= 1'b0;
         out_zero_q   <= 1'b0;
      end else begin
         mem_q        <= mem_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         out_valid_q  <= out_valid_d;
         out_result_q <= out_result_d;
         out_lost_q   <= out_lost_d;
         out_zero_q   <= out_zero_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_result = out_result_q;
   assign out_lost   = out_lost_q;
   assign out_zero   = out_zero_q;
   assign count      = count_q;

endmodule
`default_nettype wire
